// File: rtl/ss_seg_writer.sv
// Segment writer: streams a contiguous block of samples into the sample RAM,
// keeps a running sum, and publishes the written range when the segment completes.
module ss_seg_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_addr_base,
    input  logic [ADDR_WIDTH:0]              i_count,
    input  logic                             i_valid,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_ready,
    output logic                             o_we_ram,
    output logic [ADDR_WIDTH-1:0]            o_addr_ram,
    output logic [DATA_WIDTH-1:0]            o_data_ram,
    output logic [ADDR_WIDTH-1:0]            o_addr_si,
    output logic [ADDR_WIDTH-1:0]            o_addr_ei,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_sum,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);

    localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   base;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH:0]     remaining;
    logic [SUM_W-1:0]        acc;
    logic                    err;
    logic                    accept;
    logic                    bad_count;

    assign bad_count = (i_count == '0) || (i_count > DEPTH);

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_err    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = bad_count ? DONE : WRITE;
                end
            end
            WRITE: begin
                o_ready = 1'b1;
                o_busy  = 1'b1;
                accept  = i_valid;
                if (i_valid && (remaining == (ADDR_WIDTH+1)'(1))) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                o_busy   = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                o_done   = 1'b1;
                o_err    = err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write port and segment result registers; reset clears only what is visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err        <= 1'b0;
            o_we_ram   <= 1'b0;
            o_addr_ram <= '0;
            o_data_ram <= '0;
            o_addr_si  <= '0;
            o_addr_ei  <= '0;
            o_sum      <= '0;
        end else begin
            o_we_ram <= accept;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base <= i_addr_base;
                        err  <= bad_count;
                        if (!bad_count) begin
                            ptr       <= i_addr_base;
                            remaining <= i_count;
                            acc       <= '0;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        o_addr_ram <= ptr;
                        o_data_ram <= i_data;
                        acc        <= acc + {{ADDR_WIDTH{1'b0}}, i_data};
                        ptr        <= ptr + ADDR_WIDTH'(1);
                        remaining  <= remaining - (ADDR_WIDTH+1)'(1);
                    end
                end
                FLUSH: begin
                    // Commit on entry to DONE so the range is stable while o_done is high;
                    // o_addr_ram still holds the last written address here.
                    o_addr_si <= base;
                    o_addr_ei <= o_addr_ram;
                    o_sum     <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_seg_writer.sv
// Randomised bench for ss_seg_writer, checked every cycle against a transaction-level model.
module tb_ss_seg_writer;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [AW-1:0]    i_addr_base;
    logic [AW:0]      i_count;
    logic             i_valid;
    logic [DW-1:0]    i_data;
    logic             o_ready;
    logic             o_we_ram;
    logic [AW-1:0]    o_addr_ram;
    logic [DW-1:0]    o_data_ram;
    logic [AW-1:0]    o_addr_si;
    logic [AW-1:0]    o_addr_ei;
    logic [DW+AW-1:0] o_sum;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    ss_seg_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_addr_base(i_addr_base),
        .i_count    (i_count),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_we_ram   (o_we_ram),
        .o_addr_ram (o_addr_ram),
        .o_data_ram (o_data_ram),
        .o_addr_si  (o_addr_si),
        .o_addr_ei  (o_addr_ei),
        .o_sum      (o_sum),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, derived from segment-level bookkeeping.
    logic             exp_ready = 0, exp_we = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
    logic [AW-1:0]    exp_addr = 0, exp_si = 0, exp_ei = 0;
    logic [DW-1:0]    exp_data = 0;
    logic [DW+AW-1:0] exp_sum = 0;
    int  m_base = 0, m_cnt = 0, m_idx = 0, m_acc = 0, done_cd = 0;
    bit  m_seg = 0;

    always @(posedge clk) begin : model
        bit cur_idle, n_we, n_done, n_err;
        if (rst) begin
            exp_ready = 0; exp_we = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
            exp_addr = 0; exp_data = 0; exp_si = 0; exp_ei = 0; exp_sum = 0;
            m_seg = 0; done_cd = 0; m_idx = 0; m_acc = 0;
        end else begin
            cur_idle = !exp_busy && !exp_done;
            n_we = 0; n_done = 0; n_err = 0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin
                    n_done  = 1;
                    exp_si  = AW'(m_base);
                    exp_ei  = AW'((m_base + m_cnt - 1) % DEPTH);
                    exp_sum = (DW+AW)'(m_acc);
                end
            end
            if (exp_ready && i_valid) begin
                n_we     = 1;
                exp_addr = AW'((m_base + m_idx) % DEPTH);
                exp_data = i_data;
                m_acc    = m_acc + int'(i_data);
                m_idx++;
                if (m_idx == m_cnt) begin
                    m_seg   = 0;
                    done_cd = 1;
                end
            end
            if (cur_idle && i_start) begin
                if (int'(i_count) == 0 || int'(i_count) > DEPTH) begin
                    n_done = 1;
                    n_err  = 1;
                end else begin
                    m_base = int'(i_addr_base);
                    m_cnt  = int'(i_count);
                    m_idx  = 0;
                    m_acc  = 0;
                    m_seg  = 1;
                end
            end
            exp_we    = n_we;
            exp_done  = n_done;
            exp_err   = n_err;
            exp_ready = m_seg;
            exp_busy  = m_seg || (done_cd > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(o_ready), 32'(exp_ready));
            chk("we",    32'(o_we_ram), 32'(exp_we));
            chk("busy",  32'(o_busy), 32'(exp_busy));
            chk("done",  32'(o_done), 32'(exp_done));
            chk("err",   32'(o_err), 32'(exp_err));
            chk("si",    32'(o_addr_si), 32'(exp_si));
            chk("ei",    32'(o_addr_ei), 32'(exp_ei));
            chk("sum",   32'(o_sum), 32'(exp_sum));
            if (exp_we) begin
                chk("waddr", 32'(o_addr_ram), 32'(exp_addr));
                chk("wdata", 32'(o_data_ram), 32'(exp_data));
            end
        end
    end

    logic [DW-1:0] dbuf [DEPTH];
    bit            vpat [6] = '{1, 0, 0, 1, 0, 1};

    task automatic do_start(input int b, input int c);
        i_start     = 1;
        i_addr_base = AW'(b);
        i_count     = (AW+1)'(c);
        @(negedge clk);
        i_start     = 0;
    endtask

    // vmode: 0 = valid held high, 1 = random valid, 2 = fixed toggle pattern
    task automatic send(input int n, input int vmode, input bit pulse);
        int idx = 0;
        int g   = 0;
        while (idx < n && g < 2000) begin
            case (vmode)
                0:       i_valid = 1;
                1:       i_valid = 1'($urandom_range(0, 1));
                default: i_valid = vpat[g % 6];
            endcase
            i_data = dbuf[idx];
            if (pulse) begin
                i_start     = ($urandom_range(0, 3) == 0);
                i_addr_base = AW'($urandom);
                i_count     = (AW+1)'($urandom_range(1, 64));
            end
            if (exp_ready && i_valid) idx++;
            @(negedge clk);
            g++;
        end
        i_valid = 0;
        i_start = 0;
        if (g >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: got %0d beats expected %0d", idx, n);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!exp_done && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, c;
        rst = 1; i_start = 0; i_addr_base = 0; i_count = 0; i_valid = 0; i_data = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_we",    32'(o_we_ram), 0);
        chk("rst_sum",   32'(o_sum), 0);
        rst = 0;
        @(negedge clk);

        // basic segment
        for (int i = 0; i < 5; i++) dbuf[i] = DW'(10 * (i + 1));
        do_start(4, 5);
        send(5, 0, 0);
        wait_done();
        chk("basic_si",  32'(o_addr_si), 4);
        chk("basic_ei",  32'(o_addr_ei), 8);
        chk("basic_sum", 32'(o_sum), 150);
        chk("basic_err", 32'(o_err), 0);
        chk("model_basic_sum", 32'(exp_sum), 150);
        @(negedge clk);

        // wrap-around
        for (int i = 0; i < 4; i++) dbuf[i] = DW'(i + 1);
        do_start(62, 4);
        send(4, 0, 0);
        wait_done();
        chk("wrap_si",  32'(o_addr_si), 62);
        chk("wrap_ei",  32'(o_addr_ei), 1);
        chk("wrap_sum", 32'(o_sum), 10);
        @(negedge clk);

        // source backpressure
        dbuf[0] = 7; dbuf[1] = 8; dbuf[2] = 9;
        do_start(10, 3);
        send(3, 2, 0);
        wait_done();
        chk("bp_ei",  32'(o_addr_ei), 12);
        chk("bp_sum", 32'(o_sum), 24);
        @(negedge clk);

        // full depth with stray starts during the segment
        for (int i = 0; i < DEPTH; i++) dbuf[i] = 8'hFF;
        do_start(0, 64);
        send(64, 0, 1);
        wait_done();
        chk("full_si",  32'(o_addr_si), 0);
        chk("full_ei",  32'(o_addr_ei), 63);
        chk("full_sum", 32'(o_sum), 16320);
        chk("model_full_sum", 32'(exp_sum), 16320);
        @(negedge clk);

        // illegal counts leave the published range untouched
        do_start(5, 0);
        wait_done();
        chk("err0_err", 32'(o_err), 1);
        chk("err0_sum", 32'(o_sum), 16320);
        @(negedge clk);
        do_start(9, 65);
        wait_done();
        chk("err65_err", 32'(o_err), 1);
        chk("err65_ei",  32'(o_addr_ei), 63);
        @(negedge clk);

        // reset in the middle of a segment
        for (int i = 0; i < 5; i++) dbuf[i] = DW'(i + 1);
        do_start(20, 5);
        send(2, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_busy",  32'(o_busy), 0);
        chk("mid_rst_ready", 32'(o_ready), 0);
        chk("mid_rst_sum",   32'(o_sum), 0);
        chk("mid_rst_done",  32'(o_done), 0);
        rst = 0;
        @(negedge clk);
        dbuf[0] = 100; dbuf[1] = 5; dbuf[2] = 1;
        do_start(30, 3);
        send(3, 0, 0);
        wait_done();
        chk("after_rst_si",  32'(o_addr_si), 30);
        chk("after_rst_sum", 32'(o_sum), 106);
        @(negedge clk);

        // random segments, including occasional illegal counts
        for (int s = 0; s < 24; s++) begin
            b = $urandom_range(0, DEPTH - 1);
            c = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(65, 127))
                                             : $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) dbuf[i] = DW'($urandom);
            do_start(b, c);
            if (c >= 1 && c <= DEPTH) send(c, 1, ($urandom_range(0, 1) == 1));
            wait_done();
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
